// File: rtl/bcd_serial_add_ctrl_if.sv
// rtl/bcd_serial_add_ctrl_if.sv - request/result bundle for the serial BCD adder
interface bcd_serial_add_ctrl_if #(
  parameter int NDIGITS = 4
);
  logic                   start;
  logic [4*NDIGITS-1:0]   a;
  logic [4*NDIGITS-1:0]   b;
  logic                   cin;
  logic                   busy;
  logic                   done;
  logic [4*NDIGITS-1:0]   sum;
  logic                   cout;
  logic                   err;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout, err
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout, err
  );
endinterface

// File: rtl/bcd_serial_add_ctrl.sv
// rtl/bcd_serial_add_ctrl.sv - digit-serial packed-BCD adder, one digit per cycle
// A single 4-bit BCD digit adder is walked across the captured operands LSD first.
module bcd_serial_add_ctrl #(
  parameter int NDIGITS = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  bcd_serial_add_ctrl_if.slave       bus
);

  localparam int W  = 4 * NDIGITS;
  localparam int IW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;

  logic [W-1:0]    op_a;
  logic [W-1:0]    op_b;
  logic [W-1:0]    sum_q;
  logic [IW-1:0]   idx;
  logic            carry;
  logic            cout_q;
  logic            err_q;

  logic            accept;
  logic            last_digit;
  logic [IW+1:0]   bit_base;
  logic [3:0]      dig_a;
  logic [3:0]      dig_b;
  logic [4:0]      raw;
  logic [4:0]      adj;
  logic            over_nine;
  logic [3:0]      dig_sum;

  function automatic logic has_bad_digit(input logic [W-1:0] v);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < NDIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) bad = 1'b1;
    end
    return bad;
  endfunction

  // Shared single-digit datapath: operands selected by idx.
  always_comb begin
    bit_base  = {idx, 2'b00};
    dig_a     = op_a[bit_base +: 4];
    dig_b     = op_b[bit_base +: 4];
    raw       = {1'b0, dig_a} + {1'b0, dig_b} + {4'b0000, carry};
    adj       = raw + 5'd6;
    over_nine = (raw > 5'd9);
    dig_sum   = over_nine ? adj[3:0] : raw[3:0];
  end

  assign last_digit = (idx == IW'(NDIGITS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    bus.busy  = 1'b0;
    bus.done  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          accept    = 1'b1;
          state_nxt = ADD;
        end
      end
      ADD: begin
        bus.busy = 1'b1;
        if (last_digit) state_nxt = DONE;
      end
      DONE: begin
        bus.done  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_a   <= '0;
      op_b   <= '0;
      sum_q  <= '0;
      idx    <= '0;
      carry  <= 1'b0;
      cout_q <= 1'b0;
      err_q  <= 1'b0;
    end else if (accept) begin
      op_a   <= bus.a;
      op_b   <= bus.b;
      carry  <= bus.cin;
      idx    <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      err_q  <= has_bad_digit(bus.a) | has_bad_digit(bus.b);
    end else if (state == ADD) begin
      sum_q[bit_base +: 4] <= dig_sum;
      carry                <= over_nine;
      if (last_digit) begin
        cout_q <= over_nine;
        idx    <= '0;
      end else begin
        idx    <= idx + IW'(1);
      end
    end
  end

  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.err  = err_q;

endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// tb/tb_bcd_serial_add_ctrl.sv - directed bench for the serial BCD adder
module tb_bcd_serial_add_ctrl;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_miss;

  bcd_serial_add_ctrl_if #(.NDIGITS(4)) bus ();

  bcd_serial_add_ctrl #(.NDIGITS(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the done cycle.
  task automatic do_add(input string tag, input logic [15:0] va, input logic [15:0] vb,
                        input logic vc, input logic [15:0] es, input logic ec,
                        input logic ee, input bit poke);
    int busy_cnt;
    int guard;
    bit seen;
    bus.a     = va;
    bus.b     = vb;
    bus.cin   = vc;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.a     = 16'($urandom);
    bus.b     = 16'($urandom);
    bus.cin   = ~vc;
    busy_cnt  = 0;
    guard     = 0;
    seen      = 0;
    while (guard < 20 && !seen) begin
      if (bus.done) begin
        seen = 1;
      end else begin
        if (bus.busy) busy_cnt++;
        if (poke && busy_cnt == 2) begin
          bus.start = 1'b1;
          bus.a     = 16'h9999;
          bus.b     = 16'h9999;
          bus.cin   = 1'b1;
        end else begin
          bus.start = 1'b0;
        end
        @(negedge clk);
        guard++;
      end
    end
    bus.start = 1'b0;
    check({tag, "_done"}, 64'(seen), 64'd1);
    check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'd4);
    check({tag, "_sum"}, 64'(bus.sum), 64'(es));
    check({tag, "_cout"}, 64'(bus.cout), 64'(ec));
    check({tag, "_err"}, 64'(bus.err), 64'(ee));
    @(negedge clk);
    check({tag, "_done_pulse"}, 64'(bus.done), 64'd0);
    check({tag, "_sum_hold"}, 64'(bus.sum), 64'(es));
  endtask

  initial begin
    int  cyc;
    bit  any_done;
    n_vec     = 0;
    n_miss    = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.cin   = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_sum",  64'(bus.sum),  64'd0);
    check("rst_cout", 64'(bus.cout), 64'd0);
    check("rst_err",  64'(bus.err),  64'd0);

    rst = 1'b0;
    do_add("add_1234_5678", 16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0, 0);

    bus.a = 16'h4444;
    bus.b = 16'h4444;
    repeat (3) @(negedge clk);
    check("idle_hold_sum",  64'(bus.sum),  64'h6912);
    check("idle_hold_busy", 64'(bus.busy), 64'd0);

    do_add("add_9999_0001", 16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 0);
    do_add("add_cin_only",  16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0, 0);
    do_add("add_poke",      16'h0250, 16'h0375, 1'b0, 16'h0625, 1'b0, 1'b0, 1);
    do_add("add_bad_digit", 16'h000F, 16'h0001, 1'b0, 16'h0016, 1'b0, 1'b1, 0);
    do_add("add_err_clear", 16'h5000, 16'h5000, 1'b0, 16'h0000, 1'b1, 1'b0, 0);
    check("err_held_after_clear_add", 64'(bus.err), 64'd0);

    // Back-to-back with start held high.
    bus.a     = 16'h1234;
    bus.b     = 16'h5678;
    bus.cin   = 1'b0;
    bus.start = 1'b1;
    @(negedge clk);
    bus.a = 16'h0005;
    bus.b = 16'h0005;
    cyc   = 1;
    while (!bus.done && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("b2b_done_cycle", 64'(cyc), 64'd5);
    check("b2b_first_sum", 64'(bus.sum), 64'h6912);
    @(negedge clk);
    check("b2b_idle_busy", 64'(bus.busy), 64'd0);
    check("b2b_first_hold", 64'(bus.sum), 64'h6912);
    @(negedge clk);
    check("b2b_reaccept", 64'(bus.busy), 64'd1);
    bus.start = 1'b0;
    cyc = 0;
    while (!bus.done && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("b2b_second_done", 64'(bus.done), 64'd1);
    check("b2b_second_sum", 64'(bus.sum), 64'h0010);
    check("b2b_second_cout", 64'(bus.cout), 64'd0);
    @(negedge clk);

    // Reset during the second ADD cycle aborts without a done pulse.
    bus.a     = 16'h1234;
    bus.b     = 16'h5678;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    check("abort_in_add", 64'(bus.busy), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy", 64'(bus.busy), 64'd0);
    check("abort_sum",  64'(bus.sum),  64'd0);
    check("abort_done", 64'(bus.done), 64'd0);
    rst = 1'b0;
    any_done = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.done) any_done = 1;
    end
    check("abort_no_done", 64'(any_done), 64'd0);
    do_add("after_abort", 16'h0808, 16'h0303, 1'b1, 16'h1112, 1'b0, 1'b0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
